laser_rate_monitor: RTL and testbench

- Sits directly downstream of the laser gate counter and consumes its 32-bit per-gate (1 s at 50 MHz) laser pulse count.
- Produces four results for the Ethernet register/host interface:
  - moving average over 2^AVG_LOG2 gates
  - min/max since clear
  - out-of-window alarm
  - stale-source flag
- The latest average is also offered to the host on a valid/ready handshake.

---
 rtl/laser_rate_monitor.sv | 188 ++++++++++++++++++
 tb/tb_laser_rate_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/laser_rate_monitor.sv
// Laser rate monitor: moving average, min/max, window alarm, stale detection and host handshake.
// Optional min/max tracking is built when LASER_RATE_MINMAX_EN is defined; otherwise MinRate/MaxRate are 0.
module laser_rate_monitor #(
    parameter int unsigned AVG_LOG2       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 75000000,
    parameter int unsigned ALARM_COUNT    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RateStrobe,
    input  logic [31:0] RateIn,
    input  logic [31:0] LowLimit,
    input  logic [31:0] HighLimit,
    input  logic        ClearStats,
    output logic [31:0] AvgRate,
    output logic        AvgValid,
    output logic [31:0] MinRate,
    output logic [31:0] MaxRate,
    output logic        Alarm,
    output logic        Stale,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutData,
    output logic        OutOverrun
);

    localparam int unsigned         DEPTH     = 1 << AVG_LOG2;
    localparam int unsigned         SUM_W     = 32 + AVG_LOG2;
    localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0]   FILL_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1);
    localparam logic [31:0]         TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]          ALARM_THR = 4'(ALARM_COUNT);

    typedef enum logic {FILL, RUN} state_t;

    state_t              r_state, w_state_next;
    logic [31:0]         r_buf [DEPTH];
    logic [AVG_LOG2-1:0] r_ptr;
    logic [AVG_LOG2:0]   r_fill, w_fill_next;
    logic [SUM_W-1:0]    r_sum, w_sum_next, w_sum_add;
    logic [31:0]         r_avg, w_avg_next;
    logic                r_avg_valid, w_avg_valid_next;
    logic [31:0]         r_timeout;
    logic                w_timeout_hit;
    logic                r_stale;
    logic [3:0]          r_alarm_cnt, w_alarm_cnt_inc;
    logic                r_alarm;
    logic                w_in_window;
    logic                w_load;
    logic                r_out_valid;
    logic [31:0]         r_out_data;
    logic                r_overrun;

    assign w_sum_add       = r_sum + SUM_W'(RateIn);
    assign w_timeout_hit   = !RateStrobe && (r_timeout == TO_LAST);
    assign w_in_window     = (RateIn >= LowLimit) && (RateIn <= HighLimit);
    assign w_alarm_cnt_inc = (r_alarm_cnt == 4'hF) ? r_alarm_cnt : r_alarm_cnt + 4'd1;
    assign w_load          = RateStrobe && w_avg_valid_next;

    always_comb begin
        w_state_next     = r_state;
        w_sum_next       = r_sum;
        w_fill_next      = r_fill;
        w_avg_next       = r_avg;
        w_avg_valid_next = r_avg_valid;
        if (RateStrobe) begin
            unique case (r_state)
                FILL: begin
                    // The oldest entry is not subtracted while filling; its content is stale.
                    w_sum_next  = w_sum_add;
                    w_fill_next = r_fill + FILL_ONE;
                    if (w_fill_next == FILL_FULL) begin
                        w_state_next     = RUN;
                        w_avg_valid_next = 1'b1;
                        w_avg_next       = w_sum_next[AVG_LOG2 +: 32];
                    end
                end
                RUN: begin
                    w_sum_next = w_sum_add - SUM_W'(r_buf[r_ptr]);
                    w_avg_next = w_sum_next[AVG_LOG2 +: 32];
                end
            endcase
        end else if (w_timeout_hit) begin
            w_state_next     = FILL;
            w_sum_next       = '0;
            w_fill_next      = '0;
            w_avg_valid_next = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (RateStrobe && !Reset) begin
            r_buf[r_ptr] <= RateIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= FILL;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_timeout   <= '0;
            r_stale     <= 1'b0;
            r_alarm_cnt <= '0;
            r_alarm     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fill      <= w_fill_next;
            r_sum       <= w_sum_next;
            r_avg       <= w_avg_next;
            r_avg_valid <= w_avg_valid_next;

            if (RateStrobe) begin
                r_ptr     <= r_ptr + PTR_ONE;
                r_timeout <= '0;
                r_stale   <= 1'b0;
                if (w_in_window) begin
                    r_alarm_cnt <= '0;
                    r_alarm     <= 1'b0;
                end else begin
                    r_alarm_cnt <= w_alarm_cnt_inc;
                    if (w_alarm_cnt_inc >= ALARM_THR) begin
                        r_alarm <= 1'b1;
                    end
                end
            end else if (r_timeout != TO_LAST) begin
                r_timeout <= r_timeout + 32'd1;
            end

            if (w_timeout_hit) begin
                r_stale <= 1'b1;
            end

            // Clear first so a simultaneous overrun event still leaves the flag set.
            if (ClearStats) begin
                r_overrun <= 1'b0;
            end
            if (w_load) begin
                r_out_data  <= w_avg_next;
                r_out_valid <= 1'b1;
                if (r_out_valid && !OutReady) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && OutReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef LASER_RATE_MINMAX_EN
    logic [31:0] r_min, r_max;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_min <= '1;
            r_max <= '0;
        end else if (ClearStats) begin
            r_min <= RateStrobe ? RateIn : '1;
            r_max <= RateStrobe ? RateIn : '0;
        end else if (RateStrobe) begin
            if (RateIn < r_min) r_min <= RateIn;
            if (RateIn > r_max) r_max <= RateIn;
        end
    end

    assign MinRate = r_min;
    assign MaxRate = r_max;
`else
    assign MinRate = '0;
    assign MaxRate = '0;
`endif

    assign AvgRate    = r_avg;
    assign AvgValid   = r_avg_valid;
    assign Alarm      = r_alarm;
    assign Stale      = r_stale;
    assign OutValid   = r_out_valid;
    assign OutData    = r_out_data;
    assign OutOverrun = r_overrun;

endmodule

// File: tb/tb_laser_rate_monitor.sv
// Directed testbench for laser_rate_monitor with hand-computed expected values.
module tb_laser_rate_monitor;

    logic        Clk;
    logic        Reset;
    logic        RateStrobe;
    logic [31:0] RateIn;
    logic [31:0] LowLimit;
    logic [31:0] HighLimit;
    logic        ClearStats;
    logic [31:0] AvgRate;
    logic        AvgValid;
    logic [31:0] MinRate;
    logic [31:0] MaxRate;
    logic        Alarm;
    logic        Stale;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;
    logic        OutOverrun;

    int unsigned errors = 0;
    int unsigned checks = 0;

    laser_rate_monitor #(
        .AVG_LOG2      (3),
        .TIMEOUT_CYCLES(100),
        .ALARM_COUNT   (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RateStrobe(RateStrobe),
        .RateIn    (RateIn),
        .LowLimit  (LowLimit),
        .HighLimit (HighLimit),
        .ClearStats(ClearStats),
        .AvgRate   (AvgRate),
        .AvgValid  (AvgValid),
        .MinRate   (MinRate),
        .MaxRate   (MaxRate),
        .Alarm     (Alarm),
        .Stale     (Stale),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutOverrun(OutOverrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] mm(input logic [31:0] v);
`ifdef LASER_RATE_MINMAX_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic strobe(input logic [31:0] v, input logic clr);
        @(negedge Clk);
        RateStrobe = 1'b1;
        RateIn     = v;
        ClearStats = clr;
        @(posedge Clk);
        #1;
        RateStrobe = 1'b0;
        ClearStats = 1'b0;
    endtask

    task automatic clear_only();
        @(negedge Clk);
        ClearStats = 1'b1;
        @(posedge Clk);
        #1;
        ClearStats = 1'b0;
    endtask

    task automatic reset_with_strobe();
        @(negedge Clk);
        Reset      = 1'b1;
        RateStrobe = 1'b1;
        RateIn     = 32'd5;
        @(posedge Clk);
        #1;
        Reset      = 1'b0;
        RateStrobe = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_avg"},     AvgRate, 32'd0);
        check_eq({tag, "_avgv"},    32'(AvgValid), 32'd0);
        check_eq({tag, "_min"},     MinRate, mm(32'hFFFF_FFFF));
        check_eq({tag, "_max"},     MaxRate, 32'd0);
        check_eq({tag, "_alarm"},   32'(Alarm), 32'd0);
        check_eq({tag, "_stale"},   32'(Stale), 32'd0);
        check_eq({tag, "_outv"},    32'(OutValid), 32'd0);
        check_eq({tag, "_outd"},    OutData, 32'd0);
        check_eq({tag, "_overrun"}, 32'(OutOverrun), 32'd0);
    endtask

    initial begin
        Reset      = 1'b0;
        RateStrobe = 1'b0;
        RateIn     = '0;
        LowLimit   = 32'd0;
        HighLimit  = 32'hFFFF_FFFF;
        ClearStats = 1'b0;
        OutReady   = 1'b0;

        // Reset with a coincident strobe that must be ignored
        reset_with_strobe();
        check_reset_state("reset");

        // Fill: 100..800, host not ready
        for (int unsigned i = 1; i <= 7; i++) strobe(32'(i * 100), 1'b0);
        check_eq("fill7_avgv", 32'(AvgValid), 32'd0);
        check_eq("fill7_outv", 32'(OutValid), 32'd0);
        strobe(32'd800, 1'b0);
        check_eq("fill8_avgv", 32'(AvgValid), 32'd1);
        check_eq("fill8_avg",  AvgRate, 32'd450);
        check_eq("fill8_outv", 32'(OutValid), 32'd1);
        check_eq("fill8_outd", OutData, 32'd450);
        check_eq("fill8_ovr",  32'(OutOverrun), 32'd0);

        // Ring wrap with second unaccepted load -> overrun
        strobe(32'd900, 1'b0);
        check_eq("wrap_avg",  AvgRate, 32'd550);
        check_eq("ovr_outd",  OutData, 32'd550);
        check_eq("ovr_outv",  32'(OutValid), 32'd1);
        check_eq("ovr_flag",  32'(OutOverrun), 32'd1);
        clear_only();
        check_eq("ovr_clear", 32'(OutOverrun), 32'd0);
        check_eq("ovr_keepd", OutData, 32'd550);

        // Load coincident with a transfer: no overrun, valid stays high
        OutReady = 1'b1;
        strobe(32'd1000, 1'b0);
        check_eq("xfer_avg",  AvgRate, 32'd650);
        check_eq("xfer_outd", OutData, 32'd650);
        check_eq("xfer_outv", 32'(OutValid), 32'd1);
        check_eq("xfer_ovr",  32'(OutOverrun), 32'd0);
        @(posedge Clk);
        #1;
        check_eq("xfer_drop", 32'(OutValid), 32'd0);
        for (int unsigned i = 0; i < 6; i++) strobe(32'd1000, 1'b0);
        check_eq("wrap_avg_frac", AvgRate, 32'd987);
        strobe(32'd1000, 1'b0);
        check_eq("wrap_avg_1000", AvgRate, 32'd1000);

        // Alarm window 400..600
        LowLimit  = 32'd400;
        HighLimit = 32'd600;
        strobe(32'd500, 1'b0);
        check_eq("alarm_500",  32'(Alarm), 32'd0);
        strobe(32'd700, 1'b0);
        check_eq("alarm_700",  32'(Alarm), 32'd0);
        strobe(32'd300, 1'b0);
        check_eq("alarm_300",  32'(Alarm), 32'd1);
        strobe(32'd500, 1'b0);
        check_eq("alarm_clr",  32'(Alarm), 32'd0);
        LowLimit  = 32'd700;
        HighLimit = 32'd800;
        strobe(32'd700, 1'b0);
        check_eq("alarm_incl", 32'(Alarm), 32'd0);
        LowLimit  = 32'd900;
        HighLimit = 32'd100;
        strobe(32'd950, 1'b0);
        check_eq("alarm_inv1", 32'(Alarm), 32'd0);
        strobe(32'd950, 1'b0);
        check_eq("alarm_inv2", 32'(Alarm), 32'd1);
        LowLimit  = 32'd0;
        HighLimit = 32'hFFFF_FFFF;
        strobe(32'd1000, 1'b0);
        check_eq("alarm_open", 32'(Alarm), 32'd0);
        check_eq("alarm_avg",  AvgRate, 32'd700);

        // Stale after 100 idle cycles
        repeat (99) @(posedge Clk);
        #1;
        check_eq("stale_99",     32'(Stale), 32'd0);
        check_eq("stale_99_avv", 32'(AvgValid), 32'd1);
        @(posedge Clk);
        #1;
        check_eq("stale_100",     32'(Stale), 32'd1);
        check_eq("stale_100_avv", 32'(AvgValid), 32'd0);
        check_eq("stale_hold",    AvgRate, 32'd700);
        strobe(32'd2000, 1'b0);
        check_eq("stale_clr",     32'(Stale), 32'd0);
        for (int unsigned i = 0; i < 6; i++) strobe(32'd2000, 1'b0);
        check_eq("refill7_avv",   32'(AvgValid), 32'd0);
        strobe(32'd2000, 1'b0);
        check_eq("refill8_avv",   32'(AvgValid), 32'd1);
        check_eq("refill8_avg",   AvgRate, 32'd2000);

        // Min/max
        clear_only();
        check_eq("mm_clr_min", MinRate, mm(32'hFFFF_FFFF));
        check_eq("mm_clr_max", MaxRate, 32'd0);
        strobe(32'd50, 1'b0);
        strobe(32'd10, 1'b0);
        strobe(32'd90, 1'b0);
        check_eq("mm_min", MinRate, mm(32'd10));
        check_eq("mm_max", MaxRate, mm(32'd90));
        strobe(32'd30, 1'b1);
        check_eq("mm_post_min", MinRate, mm(32'd30));
        check_eq("mm_post_max", MaxRate, mm(32'd30));
        check_eq("mm_avgv",     32'(AvgValid), 32'd1);

        // Reset mid-FILL, then a full refill from a clean sum
        reset_with_strobe();
        for (int unsigned i = 0; i < 3; i++) strobe(32'd77, 1'b0);
        reset_with_strobe();
        check_reset_state("rst_mid");
        for (int unsigned i = 0; i < 7; i++) strobe(32'd40, 1'b0);
        check_eq("post_rst7_avv", 32'(AvgValid), 32'd0);
        strobe(32'd40, 1'b0);
        check_eq("post_rst8_avv", 32'(AvgValid), 32'd1);
        check_eq("post_rst8_avg", AvgRate, 32'd40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
